zzlab_env_axil_master: RTL

- Single-outstanding AXI4-Lite master that turns a simple command/response stream into control-bus transactions.
- Sits directly upstream of the zzlab_env control slave; its m_axi_control_* ports connect 1:1 to the slave's s_axi_control_* ports.
- Used by the bring-up sequencer and the host mailbox to read the version/platform/board registers and to write control registers.
- Adds a bounded timeout so a hung slave cannot wedge the command source.

---
 rtl/zzlab_env_pkg.sv | 26 ++
 rtl/zzlab_env_axil_master.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/zzlab_env_pkg.sv
// Shared types and constants for the zzlab_env control-bus master.
// Holds the FSM encoding, AXI response codes and control register map.
package zzlab_env_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_WRESP = 3'd2,
      S_READ  = 3'd3,
      S_RDATA = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [5:0] REG_AP_CTRL  = 6'h00;
   localparam logic [5:0] REG_GIE      = 6'h04;
   localparam logic [5:0] REG_IER      = 6'h08;
   localparam logic [5:0] REG_ISR      = 6'h0C;
   localparam logic [5:0] REG_VERSION  = 6'h10;
   localparam logic [5:0] REG_PLATFORM = 6'h18;
   localparam logic [5:0] REG_BOARD    = 6'h1C;
   localparam logic [5:0] REG_CTRL     = 6'h20;

endpackage

// File: rtl/zzlab_env_axil_master.sv
// Single-outstanding AXI4-Lite master: command/response stream to control bus.
// A bounded timer aborts hung transactions with a SLVERR/timeout response.
module zzlab_env_axil_master
   import zzlab_env_pkg::*;
#(
   parameter int C_M_AXI_CONTROL_ADDR_WIDTH = 6,
   parameter int C_M_AXI_CONTROL_DATA_WIDTH = 32,
   parameter int C_TIMEOUT_CYCLES           = 256
) (
   input  logic                                    ap_clk,
   input  logic                                    ap_rst_n,
   input  logic                                    cmd_valid,
   output logic                                    cmd_ready,
   input  logic                                    cmd_write,
   input  logic [C_M_AXI_CONTROL_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_CONTROL_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_CONTROL_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                                    rsp_valid,
   input  logic                                    rsp_ready,
   output logic [C_M_AXI_CONTROL_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                              rsp_resp,
   output logic                                    rsp_timeout,
   output logic                                    m_axi_control_AWVALID,
   input  logic                                    m_axi_control_AWREADY,
   output logic [C_M_AXI_CONTROL_ADDR_WIDTH-1:0]   m_axi_control_AWADDR,
   output logic                                    m_axi_control_WVALID,
   input  logic                                    m_axi_control_WREADY,
   output logic [C_M_AXI_CONTROL_DATA_WIDTH-1:0]   m_axi_control_WDATA,
   output logic [C_M_AXI_CONTROL_DATA_WIDTH/8-1:0] m_axi_control_WSTRB,
   input  logic                                    m_axi_control_BVALID,
   output logic                                    m_axi_control_BREADY,
   input  logic [1:0]                              m_axi_control_BRESP,
   output logic                                    m_axi_control_ARVALID,
   input  logic                                    m_axi_control_ARREADY,
   output logic [C_M_AXI_CONTROL_ADDR_WIDTH-1:0]   m_axi_control_ARADDR,
   input  logic                                    m_axi_control_RVALID,
   output logic                                    m_axi_control_RREADY,
   input  logic [C_M_AXI_CONTROL_DATA_WIDTH-1:0]   m_axi_control_RDATA,
   input  logic [1:0]                              m_axi_control_RRESP
);

   localparam int AW = C_M_AXI_CONTROL_ADDR_WIDTH;
   localparam int DW = C_M_AXI_CONTROL_DATA_WIDTH;
   localparam bit TO_EN = (C_TIMEOUT_CYCLES > 0);
   localparam int TW = TO_EN ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMAX =
      TO_EN ? TW'(C_TIMEOUT_CYCLES - 1) : '0;

   state_t            state;
   state_t            state_nxt;
   logic              live;
   logic              aw_done;
   logic              w_done;
   logic [TW-1:0]     tmr;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     wdata;
   logic [DW/8-1:0]   wstrb;
   logic [DW-1:0]     rdata;
   logic [1:0]        resp;
   logic              tout;

   logic accept;
   logic aw_hs;
   logic w_hs;
   logic busy;
   logic expire;
   logic done_ok;

   // Bus-facing handshakes and outputs decode straight from registered state.
   assign cmd_ready             = live && (state == S_IDLE);
   assign rsp_valid             = (state == S_RESP);
   assign m_axi_control_AWVALID = (state == S_WRITE) && !aw_done;
   assign m_axi_control_WVALID  = (state == S_WRITE) && !w_done;
   assign m_axi_control_ARVALID = (state == S_READ);
   assign m_axi_control_BREADY  = (state == S_WRESP);
   assign m_axi_control_RREADY  = (state == S_RDATA);
   assign m_axi_control_AWADDR  = addr;
   assign m_axi_control_ARADDR  = addr;
   assign m_axi_control_WDATA   = wdata;
   assign m_axi_control_WSTRB   = wstrb;
   assign rsp_rdata             = rdata;
   assign rsp_resp              = resp;
   assign rsp_timeout           = tout;

   // Next-state logic; a response in the expiry cycle beats the timeout.
   always_comb begin
      accept    = cmd_valid && cmd_ready;
      aw_hs     = m_axi_control_AWVALID && m_axi_control_AWREADY;
      w_hs      = m_axi_control_WVALID && m_axi_control_WREADY;
      busy      = (state == S_WRITE) || (state == S_WRESP) ||
                  (state == S_READ)  || (state == S_RDATA);
      expire    = TO_EN && busy && (tmr == TMAX);
      done_ok   = ((state == S_WRESP) && m_axi_control_BVALID) ||
                  ((state == S_RDATA) && m_axi_control_RVALID);
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept) state_nxt = cmd_write ? S_WRITE : S_READ;
         end
         S_WRITE: begin
            if ((aw_done || aw_hs) && (w_done || w_hs))
               state_nxt = S_WRESP;
         end
         S_WRESP: begin
            if (m_axi_control_BVALID) state_nxt = S_RESP;
         end
         S_READ: begin
            if (m_axi_control_ARREADY) state_nxt = S_RDATA;
         end
         S_RDATA: begin
            if (m_axi_control_RVALID) state_nxt = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (expire && !done_ok) state_nxt = S_RESP;
   end

   // State register.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) state <= S_IDLE;
      else           state <= state_nxt;
   end

   // Command latch, channel done flags, timer and response capture.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         live    <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         tmr     <= '0;
         addr    <= '0;
         wdata   <= '0;
         wstrb   <= '0;
         rdata   <= '0;
         resp    <= '0;
         tout    <= 1'b0;
      end else begin
         live <= 1'b1;
         if (accept) begin
            addr    <= cmd_addr & ~AW'(3);
            wdata   <= cmd_wdata;
            wstrb   <= cmd_wstrb;
            tmr     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
         if (busy && TO_EN) tmr <= tmr + 1'b1;
         if (expire && !done_ok) begin
            rdata <= '0;
            resp  <= RESP_SLVERR;
            tout  <= 1'b1;
         end else if ((state == S_WRESP) && m_axi_control_BVALID) begin
            rdata <= '0;
            resp  <= m_axi_control_BRESP;
            tout  <= 1'b0;
         end else if ((state == S_RDATA) && m_axi_control_RVALID) begin
            rdata <= m_axi_control_RDATA;
            resp  <= m_axi_control_RRESP;
            tout  <= 1'b0;
         end
      end
   end

endmodule
